// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - drives all 8 input combinations of a 3-input gate circuit and captures its truth table
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter logic [7:0]  EXPECTED      = 8'h78
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       dut_in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic [7:0] unstable,
    output logic       match,
    output logic       aborted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] CNT_FIRST = 8'(SETTLE_CYCLES - 2);
    localparam logic [7:0] CNT_LAST  = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] idx;
    logic [7:0] cnt;
    logic       sync_meta;
    logic       sync;
    logic       s0;
    logic       at_last;
    logic [7:0] sel;
    logic [7:0] table_wr;
    logic [7:0] unstable_wr;

    // idx is held at 0 outside APPLY, so it can drive the circuit inputs directly
    assign {dut_in1, dut_in2, dut_in3} = idx;
    assign busy    = (state == APPLY);
    assign done    = (state == DONE);
    assign at_last = (cnt == CNT_LAST);

    // two-flop synchronizer for the circuit output, which has no relation to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= dut_out;
            sync      <= sync_meta;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state plus the merged result words for the current combination (index 0 lands in the MSB)
    always_comb begin
        state_next  = state;
        sel         = 8'h80 >> idx;
        table_wr    = (table_out & ~sel) | (sync ? sel : 8'h00);
        unstable_wr = (unstable & ~sel) | ((sync != s0) ? sel : 8'h00);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (at_last && (idx == 3'd7)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // sweep counters, sampling and result registers; abort wins over a sample in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 3'd0;
            cnt       <= 8'd0;
            s0        <= 1'b0;
            table_out <= 8'h00;
            unstable  <= 8'h00;
            match     <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= 3'd0;
                        cnt       <= 8'd0;
                        table_out <= 8'h00;
                        unstable  <= 8'h00;
                        match     <= 1'b0;
                        aborted   <= 1'b0;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        idx     <= 3'd0;
                        cnt     <= 8'd0;
                        aborted <= 1'b1;
                        match   <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt == CNT_FIRST) begin
                            s0 <= sync;
                        end
                        if (at_last) begin
                            table_out <= table_wr;
                            unstable  <= unstable_wr;
                            cnt       <= 8'd0;
                            if (idx == 3'd7) begin
                                // return the inputs to 000 for DONE and publish match with done
                                idx   <= 3'd0;
                                match <= (table_wr == EXPECTED) && (unstable_wr == 8'h00);
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
